// File: rtl/dmem_if.sv
// dmem_if: core/data-memory bus; master = core (drives request, accepts response), slave = responder
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-enabled word memory answering one request after LATENCY wait states, flagging misaligned/out-of-range; ports clk, rst (sync active-high), bus (dmem_if.slave)
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0] be_q;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic accept, commit, c_we, c_err;
  logic [31:0] c_addr, c_wdata;
  logic [3:0] c_be;
  logic [ADDR_WIDTH-1:0] c_idx;
  always_comb begin
    accept  = state_q == IDLE && bus.req_valid;
    commit  = (accept && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd1);
    c_we    = state_q == IDLE ? bus.req_we : we_q;
    c_addr  = state_q == IDLE ? bus.req_addr : addr_q;
    c_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
    c_be    = state_q == IDLE ? bus.req_be : be_q;
    c_err   = c_addr[1:0] != 2'b00 || c_addr[31:ADDR_WIDTH+2] != '0;
    c_idx   = c_addr[ADDR_WIDTH+1:2];
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d   = 4'(LATENCY);
      state_d = LATENCY == 0 ? RESP : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end else if (state_q == RESP && bus.resp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (commit) begin
        err_q   <= c_err;
        rdata_q <= (c_we || c_err) ? '0 : mem[c_idx];
      end else if (state_q == RESP && bus.resp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && commit && c_we && !c_err)
      for (int i = 0; i < 4; i++)
        if (c_be[i]) mem[c_idx][8*i+:8] <= c_wdata[8*i+:8];
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder at LATENCY 0, 2 and 5
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_if b0 ();
  dmem_if b2 ();
  dmem_if b5 ();
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(5)) u5 (.clk(clk), .rst(rst), .bus(b5));
  int n_chk = 0;
  int n_pass = 0;
  logic [32:0] sb [$];
  logic [31:0] model [int];
  time acc_t, t1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic clear_bus(input virtual dmem_if v);
    v.req_valid  = 1'b0;
    v.req_we     = 1'b0;
    v.req_addr   = '0;
    v.req_wdata  = '0;
    v.req_be     = '0;
    v.resp_ready = 1'b0;
  endtask
  task automatic chk_idle(input virtual dmem_if v, input string tag);
    check(tag, 64'({v.req_ready, v.resp_valid, v.resp_err, v.resp_rdata}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
  endtask
  task automatic xact(input virtual dmem_if v, input int inst, input int lat, input logic we,
                      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input int hold, input bit ghost);
    int k;
    int key;
    logic [31:0] w;
    logic [32:0] e;
    @(negedge clk);
    v.req_valid = 1'b1;
    v.req_we    = we;
    v.req_addr  = a;
    v.req_wdata = wd;
    v.req_be    = be;
    v.resp_ready = 1'b0;
    k = 0;
    while (!v.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept", 64'(v.req_ready), 64'd1);
    if (!v.req_ready) begin
      v.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    v.req_valid = ghost;
    v.req_we    = 1'b1;
    v.req_addr  = 32'h10;
    v.req_wdata = 32'h0BAD0BAD;
    v.req_be    = 4'hF;
    key = inst * 4096 + int'(a[11:2]);
    if (a[1:0] != 2'b00 || a[31:12] != 20'h0) e = {1'b1, 32'h0};
    else if (we) begin
      w = model.exists(key) ? model[key] : 32'hx;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i+:8] = wd[8*i+:8];
      model[key] = w;
      e = '0;
    end else e = {1'b0, model.exists(key) ? model[key] : 32'hx};
    sb.push_back(e);
    k = 1;
    while (!v.resp_valid && k < 50) begin
      if (ghost) check("ghost_ready", 64'(v.req_ready), 64'd0);
      @(posedge clk);
      #1;
      v.req_valid = 1'b0;
      k++;
    end
    v.req_valid = 1'b0;
    check("latency", 64'(k), 64'(lat + 1));
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("stall", 64'({v.req_ready, v.resp_valid, v.resp_err, v.resp_rdata}), 64'({2'b01, e}));
      @(posedge clk);
      #1;
    end
    check("resp", 64'({v.resp_valid, v.resp_err, v.resp_rdata}), 64'({1'b1, e}));
    v.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    v.resp_ready = 1'b0;
    chk_idle(v, "release");
  endtask
  initial begin
    clear_bus(b0);
    clear_bus(b2);
    clear_bus(b5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle(b0, "reset_l0");
    chk_idle(b2, "reset_l2");
    chk_idle(b5, "reset_l5");
    rst = 1'b0;
    xact(b2, 2, 2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    xact(b2, 2, 2, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    xact(b2, 2, 2, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0);
    xact(b2, 2, 2, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0);
    xact(b2, 2, 2, 1'b1, 32'h10, 32'h11000000, 4'b1000, 0, 1'b0);
    xact(b2, 2, 2, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    xact(b2, 2, 2, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    xact(b2, 2, 2, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    xact(b2, 2, 2, 1'b0, 32'h1000, 32'h0, 4'hF, 0, 1'b0);
    xact(b2, 2, 2, 1'b1, 32'h10, 32'h55555555, 4'h0, 0, 1'b0);
    xact(b2, 2, 2, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0);
    xact(b2, 2, 2, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b1);
    xact(b2, 2, 2, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    xact(b2, 2, 2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    t1 = acc_t;
    xact(b2, 2, 2, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    check("b2b_l2", 64'((acc_t - t1) / 10), 64'd4);
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_we    = 1'b1;
    b2.req_addr  = 32'h20;
    b2.req_wdata = 32'h12345678;
    b2.req_be    = 4'hF;
    @(posedge clk);
    #1;
    b2.req_valid = 1'b0;
    check("midop_wait", 64'({b2.req_ready, b2.resp_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle(b2, "midop_reset");
    @(negedge clk);
    rst = 1'b0;
    xact(b2, 2, 2, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    xact(b0, 0, 0, 1'b1, 32'h40, 32'h0F0F1234, 4'hF, 0, 1'b0);
    t1 = acc_t;
    xact(b0, 0, 0, 1'b0, 32'h40, 32'h0, 4'h0, 2, 1'b0);
    check("b2b_l0", 64'((acc_t - t1) / 10), 64'd2);
    xact(b0, 0, 0, 1'b0, 32'h42, 32'h0, 4'h0, 0, 1'b0);
    xact(b5, 5, 5, 1'b1, 32'hFFC, 32'hA5A5C3C3, 4'b0110, 0, 1'b0);
    t1 = acc_t;
    xact(b5, 5, 5, 1'b1, 32'hFFC, 32'h11223344, 4'b1001, 0, 1'b0);
    check("b2b_l5", 64'((acc_t - t1) / 10), 64'd7);
    xact(b5, 5, 5, 1'b0, 32'hFFC, 32'h0, 4'h0, 3, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
